vedic_mul_seq: RTL

- Multi-cycle unsigned multiplier controller for the float_MAC mantissa path.
- Computes a DATA_W x DATA_W product by time-sharing one existing vedic_4bit core.
- Walks all nibble-pair partial products, one per clock, and accumulates them shifted into a 2*DATA_W result.
- Uses a start/ready/done handshake so the MAC sequencer can issue mantissa multiplies.

---
 rtl/vedic_mul_seq_pkg.sv | 16 +
 rtl/vedic_mul_seq_vedic4.sv | 33 +++
 rtl/vedic_mul_seq.sv | 99 +++++++++
 3 files changed

// File: rtl/vedic_mul_seq_pkg.sv
// Shared definitions for the mantissa multiplier: FSM encoding, nibble width
// and the counter-width helper.
package vedic_mul_seq_pkg;

    localparam int NIB_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A nibble index needs at least one bit even when there is only one nibble.
    function automatic int cnt_w(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/vedic_mul_seq_vedic4.sv
// Combinational 4x4 unsigned Vedic (Urdhva Tiryakbhyam) multiplier built from
// four 2x2 vertical-and-crosswise blocks.
module vedic_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] pp
);

    function automatic logic [3:0] vedic_2bit(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] r;
        logic       t1, t2, t3, c1;
        r[0] = x[0] & y[0];
        t1   = x[1] & y[0];
        t2   = x[0] & y[1];
        r[1] = t1 ^ t2;
        c1   = t1 & t2;
        t3   = x[1] & y[1];
        r[2] = t3 ^ c1;
        r[3] = t3 & c1;
        return r;
    endfunction

    logic [3:0] q0, q1, q2, q3;

    always_comb begin
        q0 = vedic_2bit(a[1:0], b[1:0]);
        q1 = vedic_2bit(a[3:2], b[1:0]);
        q2 = vedic_2bit(a[1:0], b[3:2]);
        q3 = vedic_2bit(a[3:2], b[3:2]);
        pp = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    end

endmodule

// File: rtl/vedic_mul_seq.sv
// Sequential DATA_W x DATA_W unsigned multiplier: one shared 4x4 Vedic core,
// one nibble-pair partial product per clock, shifted into a 2*DATA_W accumulator.
module vedic_mul_seq
    import vedic_mul_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int NIB   = DATA_W / NIB_W;
    localparam int STEPS = NIB * NIB;
    localparam int CW    = cnt_w(NIB);
    localparam int PW    = 2 * DATA_W;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    generate
        if ((DATA_W % NIB_W) != 0 || STEPS < 1) begin : g_bad_width
            $error("vedic_mul_seq: DATA_W must be a positive multiple of 4");
        end
    endgenerate

    logic [1:0]        state;
    logic [DATA_W-1:0] a_r, b_r;
    logic [PW-1:0]     acc, acc_next;
    logic [CW-1:0]     i, j;
    logic [CW:0]       pos;
    logic [3:0]        a_nib, b_nib;
    logic [7:0]        pp;

    vedic_4bit u_core (
        .a  (a_nib),
        .b  (b_nib),
        .pp (pp)
    );

    // Partial product weight is 16^(i+j); the sum needs one bit more than a counter.
    always_comb begin
        a_nib    = a_r[NIB_W*i +: NIB_W];
        b_nib    = b_r[NIB_W*j +: NIB_W];
        pos      = {1'b0, i} + {1'b0, j};
        acc_next = acc + ({{(PW-8){1'b0}}, pp} << (NIB_W * pos));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            i       <= '0;
            j       <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc <= acc_next;
                    if (j == LAST) begin
                        j <= '0;
                        // The final partial product goes straight into product so it is valid with done.
                        if (i == LAST) begin
                            product <= acc_next;
                            state   <= ST_DONE;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_CALC);
    assign done  = (state == ST_DONE);

endmodule
